// File: rtl/pio_edge_capture_ext.sv
// Avalon-MM parallel I/O: synchronised inputs, per-bit rise/fall edge capture
// with write-1-to-clear, maskable level interrupt and an output register with set/clear strobes.
module pio_edge_capture_ext #(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter int unsigned           SYNC_STAGES   = 2,
  parameter logic [DATA_WIDTH-1:0] RISE_EN_RESET = '1,
  parameter logic [DATA_WIDTH-1:0] FALL_EN_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [2:0] AddrData    = 3'd0;
  localparam logic [2:0] AddrOut     = 3'd1;
  localparam logic [2:0] AddrIrqMask = 3'd2;
  localparam logic [2:0] AddrEdge    = 3'd3;
  localparam logic [2:0] AddrRiseEn  = 3'd4;
  localparam logic [2:0] AddrFallEn  = 3'd5;
  localparam logic [2:0] AddrOutSet  = 3'd6;
  localparam logic [2:0] AddrOutClr  = 3'd7;

  logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_cap;
  logic [DATA_WIDTH-1:0] r_rise;
  logic [DATA_WIDTH-1:0] r_fall;
  logic [31:0]           r_readdata;

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_sync;
  logic [DATA_WIDTH-1:0] w_det;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [DATA_WIDTH-1:0] w_out_d;
  logic [DATA_WIDTH-1:0] w_mask_d;
  logic [DATA_WIDTH-1:0] w_rise_d;
  logic [DATA_WIDTH-1:0] w_fall_d;
  logic [DATA_WIDTH-1:0] w_cap_d;
  logic [31:0]           w_rd;

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[DATA_WIDTH-1:0];
  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_det   = (r_rise & w_sync & ~r_prev) | (r_fall & ~w_sync & r_prev);
  assign w_clr   = (w_wr && (address == AddrEdge)) ? w_wdata : '0;
  // A fresh edge beats a simultaneous clear so no event is lost.
  assign w_cap_d = w_det | (r_cap & ~w_clr);

  always_comb begin
    w_out_d  = r_out;
    w_mask_d = r_mask;
    w_rise_d = r_rise;
    w_fall_d = r_fall;
    if (w_wr) begin
      case (address)
        AddrOut:     w_out_d  = w_wdata;
        AddrIrqMask: w_mask_d = w_wdata;
        AddrRiseEn:  w_rise_d = w_wdata;
        AddrFallEn:  w_fall_d = w_wdata;
        AddrOutSet:  w_out_d  = r_out | w_wdata;
        AddrOutClr:  w_out_d  = r_out & ~w_wdata;
        default:     ;
      endcase
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      AddrData:    w_rd[DATA_WIDTH-1:0] = w_sync;
      AddrOut:     w_rd[DATA_WIDTH-1:0] = r_out;
      AddrIrqMask: w_rd[DATA_WIDTH-1:0] = r_mask;
      AddrEdge:    w_rd[DATA_WIDTH-1:0] = r_cap;
      AddrRiseEn:  w_rd[DATA_WIDTH-1:0] = r_rise;
      AddrFallEn:  w_rd[DATA_WIDTH-1:0] = r_fall;
      default:     w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev     <= '0;
      r_out      <= '0;
      r_mask     <= '0;
      r_cap      <= '0;
      r_rise     <= RISE_EN_RESET;
      r_fall     <= FALL_EN_RESET;
      r_readdata <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev     <= w_sync;
      r_out      <= w_out_d;
      r_mask     <= w_mask_d;
      r_cap      <= w_cap_d;
      r_rise     <= w_rise_d;
      r_fall     <= w_fall_d;
      r_readdata <= w_rd;
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_out;
  assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_pio_edge_capture_ext.sv
// Self-checking bench for pio_edge_capture_ext: directed table, hand-written corner
// sequences and a randomized run against a timeline-based reference model.
module tb_pio_edge_capture_ext;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  pio_edge_capture_ext #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(S)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .out_port  (out_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference model: the input timeline is kept as a queue of per-edge samples;
  // the synchronised value is simply the sample taken S edges ago.
  logic [7:0]  q[$];
  logic [7:0]  m_out, m_mask, m_cap, m_rise, m_fall;
  logic [31:0] m_rd;

  always @(posedge clk or negedge reset_n) begin : model
    int         n;
    logic [7:0] sy, pv, det, clr, wd, nout;
    logic       wr;
    if (!reset_n) begin
      q.delete();
      m_out  <= '0;
      m_mask <= '0;
      m_cap  <= '0;
      m_rise <= 8'hFF;
      m_fall <= 8'h00;
      m_rd   <= '0;
    end else begin
      n    = q.size();
      sy   = (n >= S)     ? q[n-S]   : 8'h00;
      pv   = (n >= S + 1) ? q[n-S-1] : 8'h00;
      wr   = chipselect && !write_n;
      wd   = writedata[7:0];
      det  = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if (m_rise[b] && sy[b] && !pv[b]) det[b] = 1'b1;
        if (m_fall[b] && !sy[b] && pv[b]) det[b] = 1'b1;
      end
      clr  = (wr && address == 3'd3) ? wd : 8'h00;
      nout = m_out;
      if (wr && address == 3'd1) nout = wd;
      if (wr && address == 3'd6) nout = m_out | wd;
      if (wr && address == 3'd7) nout = m_out & ~wd;
      case (address)
        3'd0:    m_rd <= {24'h0, sy};
        3'd1:    m_rd <= {24'h0, m_out};
        3'd2:    m_rd <= {24'h0, m_mask};
        3'd3:    m_rd <= {24'h0, m_cap};
        3'd4:    m_rd <= {24'h0, m_rise};
        3'd5:    m_rd <= {24'h0, m_fall};
        default: m_rd <= 32'h0;
      endcase
      m_out <= nout;
      if (wr && address == 3'd2) m_mask <= wd;
      if (wr && address == 3'd4) m_rise <= wd;
      if (wr && address == 3'd5) m_fall <= wd;
      m_cap <= det | (m_cap & ~clr);
      q.push_back(in_port);
      if (q.size() > 8) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks += 3;
      if (out_port !== m_out) begin
        failures++;
        $display("FAIL model_out_port t=%0t got=%h expected=%h", $time, out_port, m_out);
      end
      if (irq !== |(m_cap & m_mask)) begin
        failures++;
        $display("FAIL model_irq t=%0t got=%b expected=%b", $time, irq, |(m_cap & m_mask));
      end
      if (readdata !== m_rd) begin
        failures++;
        $display("FAIL model_readdata t=%0t got=%h expected=%h", $time, readdata, m_rd);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one bus cycle at the current negedge; returns at the following negedge.
  task automatic bus(input logic [2:0] a, input logic wr, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = !wr;
    writedata  = d;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  exp_out;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] rst_exp;

    vecs[0] = '{3'd1, 1'b1, 32'h0000_00A5, 8'hA5, 1'b0, 32'h0};
    vecs[1] = '{3'd6, 1'b1, 32'hFFFF_FF0A, 8'hAF, 1'b0, 32'h0};
    vecs[2] = '{3'd7, 1'b1, 32'h0000_0021, 8'h8E, 1'b0, 32'h0};
    vecs[3] = '{3'd1, 1'b0, 32'h0,         8'h8E, 1'b1, 32'h0000_008E};
    vecs[4] = '{3'd6, 1'b0, 32'h0,         8'h8E, 1'b1, 32'h0};
    vecs[5] = '{3'd7, 1'b0, 32'h0,         8'h8E, 1'b1, 32'h0};

    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Reset state readback
    chk("reset_irq", {31'h0, irq}, 32'h0);
    chk("reset_out_port", {24'h0, out_port}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      rst_exp = (a == 4) ? 32'hFF : 32'h0;
      bus(3'(a), 1'b0, 32'h0);
      chk($sformatf("reset_read_addr%0d", a), readdata, rst_exp);
    end

    // Rising edge on bit 0: capture and irq three clocks after the first sampling edge
    bus(3'd2, 1'b1, 32'h01);
    in_port = 8'h01;
    idle();
    chk("rise_irq_edge1", {31'h0, irq}, 32'h0);
    idle();
    chk("rise_irq_edge2", {31'h0, irq}, 32'h0);
    idle();
    chk("rise_irq_edge3", {31'h0, irq}, 32'h1);
    bus(3'd3, 1'b0, 32'h0);
    chk("rise_cap_read", readdata, 32'h01);
    bus(3'd3, 1'b1, 32'h01);
    chk("w1c_irq_drop", {31'h0, irq}, 32'h0);

    // Fall-only enable on bit 7
    bus(3'd4, 1'b1, 32'h00);
    bus(3'd5, 1'b1, 32'h80);
    in_port = 8'h81;
    repeat (4) idle();
    bus(3'd3, 1'b0, 32'h0);
    chk("fall_only_no_rise_cap", readdata, 32'h00);
    in_port = 8'h01;
    repeat (4) idle();
    bus(3'd3, 1'b0, 32'h0);
    chk("fall_cap", readdata, 32'h80);

    // Simultaneous W1C and new edge: edge on bit 1 wins, bit 0 clears
    bus(3'd4, 1'b1, 32'hFF);
    bus(3'd5, 1'b1, 32'h00);
    bus(3'd3, 1'b1, 32'hFF);
    in_port = 8'h00;
    repeat (4) idle();
    in_port = 8'h01;
    repeat (4) idle();
    bus(3'd3, 1'b0, 32'h0);
    chk("pre_race_cap", readdata, 32'h01);
    in_port = 8'h03;
    idle();
    idle();
    bus(3'd3, 1'b1, 32'h03);
    bus(3'd3, 1'b0, 32'h0);
    chk("race_cap", readdata, 32'h02);
    chk("race_irq", {31'h0, irq}, 32'h0);

    // Output register set/clear strobes, table-driven
    for (int i = 0; i < 6; i++) begin
      bus(vecs[i].addr, vecs[i].wr, vecs[i].wdata);
      chk($sformatf("out_vec%0d_out_port", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
      if (vecs[i].chk_rd) chk($sformatf("out_vec%0d_readdata", i), readdata, vecs[i].exp_rd);
    end

    // Asynchronous reset with captures pending and inputs high
    bus(3'd2, 1'b1, 32'hFF);
    chk("pre_reset_irq", {31'h0, irq}, 32'h1);
    in_port = 8'hFF;
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_out_port", {24'h0, out_port}, 32'h0);
    chk("async_reset_irq", {31'h0, irq}, 32'h0);
    chk("async_reset_readdata", readdata, 32'h0);
    @(negedge clk);
    address = 3'd3;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) idle();
    chk("post_reset_cap_edge2", readdata, 32'h00);
    idle();
    chk("post_reset_cap_edge3", readdata, 32'hFF);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = ($urandom_range(0, 2) != 0);
      write_n    = ($urandom_range(0, 1) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 2) == 0) in_port = in_port ^ 8'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_edge_capture_ext.md
# pio_edge_capture_ext

Parametrised Avalon-MM parallel I/O block: a `DATA_WIDTH` input port with a configurable synchroniser, per-bit rising/falling edge selection, write-1-to-clear edge capture and a maskable level interrupt. It also provides an output register with atomic set/clear strobes. It is the next generation of the fixed 8-bit rising-edge PIO used around the chaos-key datapath in the Qsys system, and sits on the Nios II data master as a single slave.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of `in_port`/`out_port`, 1..32.
- `SYNC_STAGES`, 2, synchroniser flops on `in_port`, 2..4.
- `RISE_EN_RESET`, all ones, reset value of the rise-enable register.
- `FALL_EN_RESET`, 0, reset value of the fall-enable register.

Ports:
- `clk` input 1: single clock; every flop uses it.
- `reset_n` input 1: reset, asynchronous assert, active-low; all state cleared.
- `address` input 3: register select.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe.
- `writedata` input 32: write data; bits above `DATA_WIDTH` ignored.
- `in_port` input DATA_WIDTH: asynchronous external inputs.
- `readdata` output 32: registered read data; bits above `DATA_WIDTH` read 0.
- `out_port` output DATA_WIDTH: output register value.
- `irq` output 1: level interrupt.

## Operation
- A write is `chipselect & ~write_n`. Reads have no side effects.
- Register map:
  - 0 DATA: read synchronised input; writes ignored.
  - 1 OUT: read/write output register.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAPTURE: read; write-1-to-clear per bit.
  - 4 RISE_EN: read/write.
  - 5 FALL_EN: read/write.
  - 6 OUT_SET: `OUT |= writedata`; reads 0.
  - 7 OUT_CLR: `OUT &= ~writedata`; reads 0.
- Synchroniser: `s[0] <= in_port`, `s[i] <= s[i-1]`, `sync = s[SYNC_STAGES-1]`. `prev <= sync`.
- Edge detect per bit: `det = (RISE_EN & sync & ~prev) | (FALL_EN & ~sync & prev)`.
- Capture per bit: if `det`, set to 1; else if a W1C write has that bit set, clear to 0; else hold.
- Capture priority: a new edge wins over a simultaneous W1C on the same bit, so no event is lost. Bits written 0 are unaffected.
- `irq = |(EDGE_CAPTURE & IRQ_MASK)`, combinational from registers, no extra delay.
- Changing RISE_EN/FALL_EN does not clear EDGE_CAPTURE. Detection uses the new enables from the cycle after the write.
- Enabling both rise and fall on a bit captures any edge. Enabling neither makes the bit's capture inert except for W1C.
- Reset values:
  - s[], `prev`, OUT, IRQ_MASK, EDGE_CAPTURE and `readdata` are 0.
  - RISE_EN = `RISE_EN_RESET`; FALL_EN = `FALL_EN_RESET`.
  - `out_port` = 0 and `irq` = 0.
- Reset mid-operation: all captured edges are lost. On release, `prev` = 0 and `sync` = 0, so no spurious edge is seen until real input transitions propagate. An input held high through reset produces one rising edge `SYNC_STAGES+1` clocks after release, if enabled.

## Timing
- Read latency 1: `readdata <= mux(address)` on every clock edge, independent of `chipselect`. Data is valid on the cycle after the address is presented.
- Register writes take effect at the clock edge that samples the write. `out_port` changes on that edge.
- Input to capture latency: `in_port` transitions before edge k. `sync` reflects it after edge k+SYNC_STAGES-1, `det` is high for one cycle, EDGE_CAPTURE is set and `irq` rises after edge k+SYNC_STAGES.
  - With `SYNC_STAGES` = 2: EDGE_CAPTURE and `irq` are high 3 clocks after the first sampling edge.
- Input to DATA readback: visible after edge k+SYNC_STAGES-1. The `readdata` register adds 1 more clock.
- Pulses shorter than one clock period may be missed; this is not required to be detected.
- W1C to `irq` deassert: 0 cycles after the write edge.

## Test plan
- Reset, then hold `in_port`=0: all reads return 0 and `irq`=0; RISE_EN reads all ones (`DATA_WIDTH`=8 → 0xFF).
- Set IRQ_MASK=0x01 and drive `in_port[0]` 0→1 with `SYNC_STAGES`=2: EDGE_CAPTURE=0x01 and `irq`=1 exactly 3 clocks after the first sampling edge. Then write 0x01 to addr 3: `irq`=0 next cycle.
- Set RISE_EN=0x00, FALL_EN=0x80, drive `in_port[7]` 1→0: EDGE_CAPTURE=0x80. A 0→1 transition on bit 7 does not capture.
- Issue a W1C of 0x03 on the same cycle `det[1]`=1 while bit 0 is captured: bit 0 clears, bit 1 remains 1.
- Write OUT=0xA5, OUT_SET=0x0A, OUT_CLR=0x21: `out_port` is 0xA5, then 0xAF, then 0x8E on successive write edges. OUT reads 0x8E; OUT_SET/OUT_CLR read 0.
- Assert `reset_n` low asynchronously with captures pending and `in_port` = 0xFF: `out_port`, `irq` and EDGE_CAPTURE drop immediately. After release, EDGE_CAPTURE = 0xFF after `SYNC_STAGES+1` clocks (default enables).
